// File: rtl/kd_pkg.sv
// rtl/kd_pkg.sv - shared states, default sizes and heap-index helpers for the kd-tree controller
package kd_pkg;

    typedef enum logic [3:0] {
        IDLE, SORT_EVEN, SORT_ODD, SORT_CHK, LVL_NEXT, READY, PROP, PROP_CHK, DONE
    } kd_state_e;

    function automatic int unsigned kd_nodes(input int unsigned lv);
        return (32'd1 << lv) - 32'd1;
    endfunction

    function automatic int unsigned kd_axis_w(input int unsigned d);
        return (d > 1) ? $clog2(d) : 1;
    endfunction

    function automatic int unsigned kd_cnt_w(input int unsigned nodes);
        return $clog2(nodes + 1);
    endfunction

    function automatic int unsigned kd_left(input int unsigned n);
        return 2 * n + 1;
    endfunction

    function automatic int unsigned kd_right(input int unsigned n);
        return 2 * n + 2;
    endfunction

    localparam int unsigned KD_DIM_DEF        = 3;
    localparam int unsigned KD_LEVELS_DEF     = 3;
    localparam int unsigned KD_MAX_PASSES_DEF = 16;
    localparam int unsigned KD_NODES          = kd_nodes(KD_LEVELS_DEF);
    localparam int unsigned KD_AXIS_W         = kd_axis_w(KD_DIM_DEF);
    localparam int unsigned KD_CNT_W          = kd_cnt_w(KD_NODES);

endpackage

// File: rtl/kd_sort_ctrl_stack.sv
// rtl/kd_sort_ctrl_stack.sv - kd_bt_stack: LIFO of pending right branches; pushes while full are dropped
module kd_bt_stack #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 3
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] top_o,
    output logic             empty_o,
    output logic             full_o
);
    localparam int unsigned PW = $clog2(DEPTH + 1);
    localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [2**IW];
    logic [PW-1:0]    sp_q, sp_d, top_idx;

    assign empty_o = (sp_q == '0);
    assign full_o  = (sp_q == PW'(DEPTH));
    assign top_idx = sp_q - PW'(1);
    assign top_o   = mem_q[top_idx[IW-1:0]];

    always_comb begin
        sp_d = sp_q;
        if (push_i && !full_o) begin
            sp_d = sp_q + PW'(1);
        end else if (pop_i && !empty_o) begin
            sp_d = sp_q - PW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sp_q <= '0;
        end else begin
            sp_q <= sp_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_i && !full_o) begin
            mem_q[sp_q[IW-1:0]] <= data_i;
        end
    end

endmodule

// File: rtl/kd_sort_ctrl.sv
// rtl/kd_sort_ctrl.sv - kd-tree sort/build and query-descent controller; KD_BACKTRACK_EN adds branch backtracking
module kd_sort_ctrl
    import kd_pkg::*;
#(
    parameter int unsigned dim        = KD_DIM_DEF,
    parameter int unsigned levels     = KD_LEVELS_DEF,
    parameter int unsigned max_passes = KD_MAX_PASSES_DEF,
    localparam int unsigned NODES = kd_nodes(levels),
    localparam int unsigned AW    = kd_axis_w(dim),
    localparam int unsigned CW    = kd_cnt_w(NODES)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [NODES-1:0] stable_vec,
    input  logic [NODES-1:0] send_left_vec,
    input  logic [NODES-1:0] send_right_vec,
    input  logic             query_valid,
    output logic             query_ready,
    output logic [NODES-1:0] ce_en,
    output logic             sorting,
    output logic             point_prop,
    output logic [AW-1:0]    axis,
    output logic             busy,
    output logic             sort_done,
    output logic             sort_err,
    output logic             result_valid,
    output logic [CW-1:0]    visit_count
);
    localparam int unsigned NW = (NODES > 1) ? $clog2(NODES) : 1;
    localparam int unsigned LW = (levels > 1) ? $clog2(levels) : 1;
    localparam int unsigned PW = (max_passes > 0) ? $clog2(max_passes + 1) : 1;

    kd_state_e        state_q, state_d;
    logic [LW-1:0]    level_q, level_d;
    logic [PW-1:0]    pass_q, pass_d;
    logic [NW-1:0]    node_q, node_d;
    logic [CW-1:0]    visit_q, visit_d;
    logic             err_q, err_d, even_ok_q, even_ok_d, odd_ok_q, odd_ok_d;
    logic [NODES-1:0] lvl_mask, even_mask, odd_mask;
    int unsigned      lvl_first;
    logic             stable_ok, last_lvl;
    logic [AW-1:0]    axis_lvl;

`ifdef KD_BACKTRACK_EN
    localparam int unsigned SW = NW + LW;
    logic          bt_push, bt_pop, bt_empty, bt_full;
    logic [SW-1:0] bt_din, bt_top;

    // Entry remembers the right child and the level it lives on.
    assign bt_din = {NW'(kd_right(32'(node_q))), level_q + LW'(1)};

    kd_bt_stack #(.WIDTH(SW), .DEPTH(levels)) u_bt_stack (
        .clk_i  (clk),
        .rst_ni (rst),
        .push_i (bt_push),
        .pop_i  (bt_pop),
        .data_i (bt_din),
        .top_o  (bt_top),
        .empty_o(bt_empty),
        .full_o (bt_full)
    );
`endif

    // Level L occupies heap indices 2^L-1 .. 2^(L+1)-2; parity is of the in-level index.
    always_comb begin
        lvl_mask  = '0;
        even_mask = '0;
        odd_mask  = '0;
        lvl_first = (32'd1 << level_q) - 32'd1;
        for (int unsigned n = 0; n < NODES; n++) begin
            if (n >= lvl_first && n <= 2 * lvl_first) begin
                lvl_mask[n] = 1'b1;
                if (((n - lvl_first) & 32'd1) == 32'd0) even_mask[n] = 1'b1;
                else                                     odd_mask[n]  = 1'b1;
            end
        end
    end

    assign stable_ok = ((stable_vec & lvl_mask) == lvl_mask);
    assign last_lvl  = (32'(level_q) == levels - 1);
    assign axis_lvl  = AW'(32'(level_q) % dim);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            level_q   <= '0;
            pass_q    <= '0;
            node_q    <= '0;
            visit_q   <= '0;
            err_q     <= 1'b0;
            even_ok_q <= 1'b0;
            odd_ok_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            level_q   <= level_d;
            pass_q    <= pass_d;
            node_q    <= node_d;
            visit_q   <= visit_d;
            err_q     <= err_d;
            even_ok_q <= even_ok_d;
            odd_ok_q  <= odd_ok_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        level_d   = level_q;
        pass_d    = pass_q;
        node_d    = node_q;
        visit_d   = visit_q;
        err_d     = err_q;
        even_ok_d = even_ok_q;
        odd_ok_d  = odd_ok_q;
`ifdef KD_BACKTRACK_EN
        bt_push   = 1'b0;
        bt_pop    = 1'b0;
`endif
        case (state_q)
            IDLE: if (start) begin
                state_d = SORT_EVEN;
                level_d = '0;
                pass_d  = '0;
                err_d   = 1'b0;
            end
            SORT_EVEN: begin
                even_ok_d = stable_ok;
                state_d   = SORT_ODD;
            end
            SORT_ODD: begin
                odd_ok_d = stable_ok;
                state_d  = SORT_CHK;
            end
            SORT_CHK: begin
                if (even_ok_q && odd_ok_q && stable_ok) begin
                    state_d = LVL_NEXT;
                end else begin
                    pass_d = pass_q + PW'(1);
                    if (32'(pass_d) >= max_passes) begin
                        err_d   = 1'b1;
                        state_d = LVL_NEXT;
                    end else begin
                        state_d = SORT_EVEN;
                    end
                end
            end
            LVL_NEXT: begin
                if (!last_lvl) begin
                    level_d = level_q + LW'(1);
                    pass_d  = '0;
                    state_d = SORT_EVEN;
                end else begin
                    state_d = READY;
                end
            end
            READY: if (query_valid) begin
                node_d  = '0;
                level_d = '0;
                visit_d = '0;
                state_d = PROP;
            end
            PROP: begin
                visit_d = visit_q + CW'(1);
                state_d = PROP_CHK;
            end
            PROP_CHK: begin
                if (!last_lvl && send_left_vec[node_q]) begin
                    node_d  = NW'(kd_left(32'(node_q)));
                    level_d = level_q + LW'(1);
                    state_d = PROP;
`ifdef KD_BACKTRACK_EN
                    bt_push = send_right_vec[node_q] && !bt_full;
`endif
                end else if (!last_lvl && send_right_vec[node_q]) begin
                    node_d  = NW'(kd_right(32'(node_q)));
                    level_d = level_q + LW'(1);
                    state_d = PROP;
                end else begin
`ifdef KD_BACKTRACK_EN
                    if (!bt_empty) begin
                        bt_pop            = 1'b1;
                        {node_d, level_d} = bt_top;
                        state_d           = PROP;
                    end else begin
                        state_d = DONE;
                    end
`else
                    state_d = DONE;
`endif
                end
            end
            DONE:    state_d = READY;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ce_en        = '0;
        sorting      = 1'b0;
        point_prop   = 1'b0;
        axis         = '0;
        busy         = 1'b1;
        query_ready  = 1'b0;
        sort_done    = 1'b0;
        result_valid = 1'b0;
        case (state_q)
            IDLE:      busy = 1'b0;
            SORT_EVEN: begin sorting = 1'b1; ce_en = even_mask; axis = axis_lvl; end
            SORT_ODD:  begin sorting = 1'b1; ce_en = odd_mask;  axis = axis_lvl; end
            LVL_NEXT:  sort_done = last_lvl;
            READY:     begin busy = 1'b0; query_ready = 1'b1; end
            PROP:      begin point_prop = 1'b1; ce_en = NODES'(1) << node_q; axis = axis_lvl; end
            DONE:      result_valid = 1'b1;
            default:   ;
        endcase
    end

    assign sort_err    = err_q;
    assign visit_count = visit_q;

endmodule

// File: tb/tb_kd_sort_ctrl.sv
// tb/tb_kd_sort_ctrl.sv - scoreboard bench for kd_sort_ctrl (levels=3, dim=3, max_passes=4)
module tb_kd_sort_ctrl;
    import kd_pkg::*;

    localparam int unsigned N = KD_NODES;

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic                start = 1'b0;
    logic                query_valid = 1'b0;
    logic [N-1:0]        stable_vec, send_left_vec, send_right_vec;
    logic                query_ready, sorting, point_prop, busy, sort_done, sort_err, result_valid;
    logic [N-1:0]        ce_en;
    logic [KD_AXIS_W-1:0] axis;
    logic [KD_CNT_W-1:0] visit_count;

    int n_cmp = 0;
    int n_bad = 0;
    int exp_node_q[$];
    int exp_vis_q[$];
    int mon_n;

    kd_sort_ctrl #(.dim(3), .levels(KD_LEVELS_DEF), .max_passes(4)) dut (
        .clk(clk), .rst(rst), .start(start), .stable_vec(stable_vec),
        .send_left_vec(send_left_vec), .send_right_vec(send_right_vec),
        .query_valid(query_valid), .query_ready(query_ready), .ce_en(ce_en),
        .sorting(sorting), .point_prop(point_prop), .axis(axis), .busy(busy),
        .sort_done(sort_done), .sort_err(sort_err), .result_valid(result_valid),
        .visit_count(visit_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int lvl_of(input int n);
        return $clog2(n + 2) - 1;
    endfunction

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_idle_outputs(input string tag);
        chk({tag, "_ce_en"}, ce_en, 0);
        chk({tag, "_sorting"}, sorting, 0);
        chk({tag, "_point_prop"}, point_prop, 0);
        chk({tag, "_axis"}, axis, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_query_ready"}, query_ready, 0);
        chk({tag, "_sort_done"}, sort_done, 0);
        chk({tag, "_sort_err"}, sort_err, 0);
        chk({tag, "_result_valid"}, result_valid, 0);
        chk({tag, "_visit_count"}, visit_count, 0);
    endtask

    // query_valid is held high throughout the build to confirm it is held off.
    task automatic build(input logic [N-1:0] stab, input int exp_lat, input logic exp_err);
        int lat = 1;
        stable_vec  = stab;
        query_valid = 1'b1;
        start       = 1'b1;
        tick();
        start = 1'b0;
        chk("build_first_sorting", sorting, 1);
        while (!sort_done && lat < 200) begin
            tick();
            lat++;
        end
        query_valid = 1'b0;
        chk("build_latency", lat, exp_lat);
        chk("qready_held", query_ready, 0);
        chk("build_sort_err", sort_err, exp_err);
        tick();
        chk("sort_done_pulse", sort_done, 0);
        chk("ready_qready", query_ready, 1);
        chk("ready_busy", busy, 0);
    endtask

    task automatic query(input string tag, input logic [N-1:0] lv, input logic [N-1:0] rv);
        int guard = 0;
        send_left_vec  = lv;
        send_right_vec = rv;
        query_valid    = 1'b1;
        tick();
        query_valid = 1'b0;
        while (!result_valid && guard < 64) begin
            tick();
            guard++;
        end
        chk({tag, "_result"}, result_valid, 1);
        tick();
        chk({tag, "_rv_pulse"}, result_valid, 0);
        chk({tag, "_back_ready"}, query_ready, 1);
        chk({tag, "_visits_left"}, exp_node_q.size(), 0);
        chk({tag, "_results_left"}, exp_vis_q.size(), 0);
    endtask

    always @(negedge clk) begin
        if (rst && point_prop) begin
            if (exp_node_q.size() == 0) begin
                chk("unexpected_visit", ce_en, 0);
            end else begin
                mon_n = exp_node_q.pop_front();
                chk("visit_ce_en", ce_en, 32'd1 << mon_n);
                chk("visit_axis", axis, lvl_of(mon_n) % 3);
            end
        end
        if (rst && result_valid) begin
            if (exp_vis_q.size() == 0) chk("unexpected_result", result_valid, 0);
            else                       chk("result_visit_count", visit_count, exp_vis_q.pop_front());
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        stable_vec     = '1;
        send_left_vec  = '0;
        send_right_vec = '0;
        #2;
        expect_idle_outputs("reset");
        #10;
        rst = 1'b1;
        tick(2);
        chk("idle_no_start_busy", busy, 0);
        chk("idle_no_start_sorting", sorting, 0);

        build('1, 12, 1'b0);

        exp_node_q = '{0, 2, 6};
        exp_vis_q.push_back(3);
        query("right_only", '0, '1);

`ifdef KD_BACKTRACK_EN
        exp_node_q = '{0, 1, 3, 2, 5};
        exp_vis_q.push_back(5);
`else
        exp_node_q = '{0, 1, 3};
        exp_vis_q.push_back(3);
`endif
        query("both_root", '1, N'(1));

        exp_node_q = '{0};
        exp_vis_q.push_back(1);
        query("no_send", '0, '0);

        exp_node_q = '{0, 1, 3};
        exp_vis_q.push_back(3);
        query("left_only", '1, '0);

        rst = 1'b0;
        #2;
        rst = 1'b1;
        build(~N'(2), 21, 1'b1);

        exp_node_q = '{0, 2, 6};
        exp_vis_q.push_back(3);
        query("after_err", '0, '1);

        query_valid = 1'b1;
        tick();
        query_valid = 1'b0;
        chk("prop_before_rst", point_prop, 1);
        rst = 1'b0;
        #1;
        expect_idle_outputs("rst_prop");
        #2;
        rst = 1'b1;
        tick(2);
        chk("idle_after_rst_busy", busy, 0);

        stable_vec = '1;
        start      = 1'b1;
        tick();
        start = 1'b0;
        chk("even_ce_en", ce_en, 1);
        chk("even_sorting", sorting, 1);
        chk("even_axis", axis, 0);
        tick();
        chk("odd_ce_en", ce_en, 0);
        chk("odd_sorting", sorting, 1);
        rst = 1'b0;
        #1;
        expect_idle_outputs("rst_odd");
        #2;
        rst = 1'b1;
        tick();

        build('1, 12, 1'b0);
        exp_node_q = '{0, 2, 6};
        exp_vis_q.push_back(3);
        query("rebuilt", '0, '1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
